nonmax_scan_ctrl: RTL
=====================

// Module: nonmax_scan_ctrl
// PURPOSE
//  Raster-scan sequencer for the nonMax stage of the edge pipeline. On start it
//  walks interior rows 1..IMG_H-2 of the gradient-magnitude/angle buffer and
//  streams 3-row column triples plus the centre-row angle into nonMax. It
//  counts nonMax results and writes each one to the edge buffer at its
//  interior (row, col) address. Sits between the magnitude buffer, nonMax and
//  the hysteresis stage's input buffer.
// PARAMETERS
//  IMG_W   102  image width in pixels (>=4)
//  IMG_H   102  image height in pixels (>=3)
//  PIX_W   5    pixel width, must equal nonMax pixel width
//  AW      $clog2(IMG_W*IMG_H)  flat address width, addr = row*IMG_W+col
// PORTS
//  clk_p_i        in   1      clock, all state on rising edge
//  reset_p_i      in   1      asynchronous, active-high reset
//  start_i        in   1      1-cycle frame start request, ignored while busy_o
//  busy_o         out  1      frame in progress
//  done_o         out  1      1-cycle pulse after last write of frame
//  err_o          out  1      sticky: unexpected/extra nonMax result; cleared on start
//  rd_en_o        out  1      magnitude-buffer read strobe, sync read, data next cycle
//  rd_addr0_o     out  AW     address, row r-1 col c
//  rd_addr1_o     out  AW     address, row r   col c
//  rd_addr2_o     out  AW     address, row r+1 col c
//  rd_pix0_i      in   PIX_W  data for rd_addr0_o (1 cycle after rd_en_o)
//  rd_pix1_i      in   PIX_W  data for rd_addr1_o
//  rd_pix2_i      in   PIX_W  data for rd_addr2_o
//  rd_ang_i       in   2      angle code of row r col c
//  nm_enable_o    out  1      nonMax enable_i
//  nm_pixel0_o    out  PIX_W  nonMax pixel_in0_i (row r-1)
//  nm_pixel1_o    out  PIX_W  nonMax pixel_in1_i (row r)
//  nm_pixel2_o    out  PIX_W  nonMax pixel_in2_i (row r+1)
//  nm_angle_o     out  2      nonMax angle_i
//  nm_pixel_i     in   PIX_W  nonMax pixel_out_o
//  nm_readable_i  in   1      nonMax readable_o
//  wr_en_o        out  1      edge-buffer write strobe
//  wr_addr_o      out  AW     edge-buffer write address
//  wr_data_o      out  PIX_W  edge-buffer write data (= nm_pixel_i)
// BEHAVIOUR
//  Reset: state IDLE; every output 0; row=1, col=0, out count=0.
//  FSM: IDLE -start_i-> ROW; ROW -col==IMG_W-1 issued-> DRAIN;
//   DRAIN -out count==IMG_W-2-> GAP; GAP (1 cycle) -> ROW if row<IMG_H-2
//   (row+1, col=0, count=0), else DONE; DONE (1 cycle, done_o=1) -> IDLE.
//  busy_o=1 in ROW/DRAIN/GAP/DONE (registered from state).
//  ROW: rd_en_o=1 each cycle, col 0..IMG_W-1, no bubbles; exactly IMG_W reads/row.
//  nm_pixel*/nm_angle_o driven combinationally from rd_* data; nm_enable_o =
//   rd_en_o delayed 1 cycle (registered), so nonMax sees IMG_W contiguous columns.
//  nm_enable_o is 0 for >=1 cycle between rows (GAP) to restart nonMax priming.
//  Each nm_readable_i in ROW/DRAIN with count<IMG_W-2: wr_en_o=1 same cycle
//   (combinational), wr_addr_o=row*IMG_W+1+count, wr_data_o=nm_pixel_i; count++.
//  nm_readable_i in IDLE/GAP/DONE or with count==IMG_W-2: no write, err_o<=1.
//  Addresses computed with row base register (row*IMG_W) incremented by IMG_W,
//   no multiplier; AW-bit arithmetic, never wraps for legal parameters.
//  Border rows/cols are never written; edge buffer owner clears them.
//  start_i while busy_o: ignored, no effect on err_o.
//  start_i coincident with done_o: ignored (busy_o still 1).
//  Reset mid-frame: immediate return to IDLE, outputs 0; no done_o pulse.
// STRUCTURE
//  Shared pkg (canny_pkg): PIX_W, ANGLE_W=2, state encoding localparams
//   (S_IDLE,S_ROW,S_DRAIN,S_GAP,S_DONE).
//  Sub-module: nonmax_addr_gen (row base, col counter, three read addresses,
//   write-address offset); FSM, counters and err logic in top.
// TESTING (IMG_W=8, IMG_H=5, nonMax behavioural model: output 2 cycles after
//  3rd enabled column)
//  T1 reset: assert reset_p_i mid-cycle -> all outputs 0 asynchronously, busy_o=0.
//  T2 full frame: start_i pulse -> 24 reads (rows 1..3 x 8 cols), 18 writes;
//   row1 wr_addr 9..14, row3 wr_addr 25..30; done_o exactly once; err_o=0.
//  T3 addresses: row 2 col 0 read -> rd_addr0/1/2 = 8/16/24; rd_ang_i passes to
//   nm_angle_o same cycle; nm_enable_o low >=1 cycle between rows.
//  T4 extra result: inject nm_readable_i in GAP -> wr_en_o=0, err_o=1 until next
//   start_i, frame still completes with done_o.
//  T5 start while busy: start_i at cycle 5 of frame -> no restart, write count 18.
//  T6 reset mid-frame: reset at row 2 col 3 -> IDLE, no done_o; new start_i ->
//   clean full frame as T2.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared constants for the edge pipeline: pixel/angle widths and the
// scan-controller state encodings.
package canny_pkg;

   localparam int PIX_W   = 5;
   localparam int ANGLE_W = 2;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_ROW   = 3'd1;
   localparam state_t S_DRAIN = 3'd2;
   localparam state_t S_GAP   = 3'd3;
   localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/nonmax_addr_gen.sv
// Address generator for the nonMax scan: keeps the row base (row*IMG_W) and
// the column counter, and forms the three read addresses plus the write
// address of the current interior result.
module nonmax_addr_gen #(
   parameter int IMG_W = 102,
   parameter int AW    = 14,
   parameter int CW    = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start,
   input  logic          row_next,
   input  logic          col_step,
   input  logic [CW-1:0] wr_offset,
   output logic          col_last,
   output logic [AW-1:0] rd_addr0,
   output logic [AW-1:0] rd_addr1,
   output logic [AW-1:0] rd_addr2,
   output logic [AW-1:0] wr_addr
);

   localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

   logic [AW-1:0] row_base;
   logic [CW-1:0] col;

   // Row base advances by one image width per row; no multiplier needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_base <= ROW_STEP;
         col      <= '0;
      end else if (frame_start) begin
         row_base <= ROW_STEP;
         col      <= '0;
      end else if (row_next) begin
         row_base <= row_base + ROW_STEP;
         col      <= '0;
      end else if (col_step) begin
         col <= col_last ? '0 : col + 1'b1;
      end
   end

   assign col_last = (col == COL_LAST);
   assign rd_addr1 = row_base + AW'(col);
   assign rd_addr0 = rd_addr1 - ROW_STEP;
   assign rd_addr2 = rd_addr1 + ROW_STEP;
   // Results cover interior columns only, so the first one lands at col 1.
   assign wr_addr  = row_base + AW'(wr_offset) + AW'(1);

endmodule

// File: rtl/nonmax_scan_ctrl.sv
// Raster-scan sequencer for the nonMax stage: streams 3-row column triples
// of interior rows into nonMax and writes each nonMax result to the edge
// buffer at its interior (row, col) address.
module nonmax_scan_ctrl #(
   parameter int IMG_W = 102,
   parameter int IMG_H = 102,
   parameter int PIX_W = canny_pkg::PIX_W,
   parameter int AW    = $clog2(IMG_W * IMG_H)
) (
   input  logic                          clk_p_i,
   input  logic                          reset_p_i,
   input  logic                          start_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic                          rd_en_o,
   output logic [AW-1:0]                 rd_addr0_o,
   output logic [AW-1:0]                 rd_addr1_o,
   output logic [AW-1:0]                 rd_addr2_o,
   input  logic [PIX_W-1:0]              rd_pix0_i,
   input  logic [PIX_W-1:0]              rd_pix1_i,
   input  logic [PIX_W-1:0]              rd_pix2_i,
   input  logic [canny_pkg::ANGLE_W-1:0] rd_ang_i,
   output logic                          nm_enable_o,
   output logic [PIX_W-1:0]              nm_pixel0_o,
   output logic [PIX_W-1:0]              nm_pixel1_o,
   output logic [PIX_W-1:0]              nm_pixel2_o,
   output logic [canny_pkg::ANGLE_W-1:0] nm_angle_o,
   input  logic [PIX_W-1:0]              nm_pixel_i,
   input  logic                          nm_readable_i,
   output logic                          wr_en_o,
   output logic [AW-1:0]                 wr_addr_o,
   output logic [PIX_W-1:0]              wr_data_o
);

   import canny_pkg::*;

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   localparam logic [CW-1:0] CNT_LAST  = CW'(IMG_W - 2);
   localparam logic [RW-1:0] ROW_FIRST = RW'(1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 2);

   state_t        state;
   logic [RW-1:0] row;
   logic [CW-1:0] count;
   logic          nm_en_q;
   logic          err_q;
   logic          frame_start;
   logic          row_next;
   logic          col_last;
   logic          wr_ok;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [AW-1:0] addr2;
   logic [AW-1:0] waddr;

   assign frame_start = (state == S_IDLE) && start_i;
   assign row_next    = (state == S_GAP) && (row < ROW_LAST);
   assign rd_en_o     = (state == S_ROW);
   assign wr_ok       = nm_readable_i && (count < CNT_LAST) &&
                        ((state == S_ROW) || (state == S_DRAIN));

   nonmax_addr_gen #(
      .IMG_W (IMG_W),
      .AW    (AW),
      .CW    (CW)
   ) u_addr_gen (
      .clk         (clk_p_i),
      .rst         (reset_p_i),
      .frame_start (frame_start),
      .row_next    (row_next),
      .col_step    (rd_en_o),
      .wr_offset   (count),
      .col_last    (col_last),
      .rd_addr0    (addr0),
      .rd_addr1    (addr1),
      .rd_addr2    (addr2),
      .wr_addr     (waddr)
   );

   // Frame sequencing, result counting, sticky error and nonMax enable delay.
   always_ff @(posedge clk_p_i or posedge reset_p_i) begin
      if (reset_p_i) begin
         state   <= S_IDLE;
         row     <= ROW_FIRST;
         count   <= '0;
         nm_en_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         nm_en_q <= rd_en_o;
         if (wr_ok) count <= count + 1'b1;
         if (nm_readable_i && !wr_ok) err_q <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state <= S_ROW;
                  row   <= ROW_FIRST;
                  count <= '0;
                  err_q <= 1'b0;
               end
            end
            S_ROW:   if (col_last) state <= S_DRAIN;
            S_DRAIN: if (count == CNT_LAST) state <= S_GAP;
            S_GAP: begin
               if (row < ROW_LAST) begin
                  state <= S_ROW;
                  row   <= row + 1'b1;
                  count <= '0;
               end else begin
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy_o = (state != S_IDLE);
   assign done_o = (state == S_DONE);
   assign err_o  = err_q;

   // Address/data outputs are gated by their strobes so they read 0 when idle.
   assign rd_addr0_o  = rd_en_o ? addr0 : '0;
   assign rd_addr1_o  = rd_en_o ? addr1 : '0;
   assign rd_addr2_o  = rd_en_o ? addr2 : '0;
   assign nm_enable_o = nm_en_q;
   assign nm_pixel0_o = nm_en_q ? rd_pix0_i : '0;
   assign nm_pixel1_o = nm_en_q ? rd_pix1_i : '0;
   assign nm_pixel2_o = nm_en_q ? rd_pix2_i : '0;
   assign nm_angle_o  = nm_en_q ? rd_ang_i  : '0;
   assign wr_en_o     = wr_ok;
   assign wr_addr_o   = wr_ok ? waddr : '0;
   assign wr_data_o   = wr_ok ? nm_pixel_i : '0;

endmodule
